diff_link_ctrl: RTL and testbench
=================================

Name: diff_link_ctrl

Overview:
- Bring-up controller for a bank of differential lanes (I_BUF_DS receivers, O_BUF_DS transmitters).
- Staggers receiver enables (the E pins) one lane at a time to limit simultaneous switching, then waits a settle period.
- Runs a toggle-pattern lock check on every lane and drives the training pattern on the transmit side.
- Declares link_up and passes user data straight through to the O_BUF_DS I pins. Sits between the buffer instances and user logic.

Parameters:
- N_LANES, 4: number of differential lanes; must be >= 1.
- SETTLE_CYCLES, 16: cycles between successive lane enables, and after the last enable; must be >= 1.
- LOCK_COUNT, 8: consecutive correct toggles a lane needs before it counts as locked; must be >= 1.
- TIMEOUT_CYCLES, 1024: maximum cycles allowed in TRAIN before FAIL.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; high requests the link up, low powers the lanes down.
- retrain  in  1  pulse; in UP, forces a return to TRAIN.
- rx_data  in  N_LANES  from the I_BUF_DS O pins.
- tx_data_in  in  N_LANES  user transmit data.
- rx_en  out  N_LANES  to the I_BUF_DS E pins.
- tx_out  out  N_LANES  to the O_BUF_DS I pins.
- lane_locked  out  N_LANES  per-lane lock status.
- link_up  out  1  high only in UP.
- train_fail  out  1  high only in FAIL.
- state  out  3  current FSM state encoding.

Behaviour:
- Reset values: state=OFF, rx_en=0, tx_out=0, lane_locked=0, link_up=0, train_fail=0; all counters 0. Every output is registered.
- States: OFF, ENABLE, SETTLE, TRAIN, UP, FAIL.
- OFF:
  - rx_en=0, tx_out=0.
  - start=1 -> ENABLE next cycle, with rx_en[0] set on that same edge.
- ENABLE:
  - The stagger counter counts to SETTLE_CYCLES-1, then sets the next rx_en bit (LSB first).
  - rx_en[i] rises exactly i*SETTLE_CYCLES cycles after rx_en[0].
  - SETTLE_CYCLES cycles after the last bit is set -> SETTLE. With N_LANES=1, ENABLE lasts SETTLE_CYCLES cycles.
- SETTLE:
  - Holds for SETTLE_CYCLES cycles, then -> TRAIN.
  - Lane checkers and the timeout counter are cleared on entry to TRAIN.
- TRAIN:
  - tx_out = {N_LANES{tog}}; tog starts at 0 on entry and inverts every cycle.
  - Per-lane check: the first cycle only captures prev. After that, rx!=prev -> count++ (saturating at LOCK_COUNT); rx==prev -> count=0.
  - lane_locked[i] = (count==LOCK_COUNT), registered. It drops the cycle after a failed toggle.
  - All lanes locked -> UP next cycle.
  - Timeout counter reaching TIMEOUT_CYCLES-1 without all locked -> FAIL.
  - Lock and timeout in the same cycle: lock wins.
- UP:
  - link_up=1; tx_out=tx_data_in, registered (1-cycle latency).
  - Checkers are frozen and lane_locked holds at all-ones.
  - retrain=1 -> TRAIN; link_up drops on that edge.
- FAIL:
  - train_fail=1, tx_out=0, rx_en held.
  - Leaves only through start=0.
- start=0 in any non-OFF state -> OFF next edge: rx_en=0, tx_out=0, lane_locked=0, link_up=0, train_fail=0, counters cleared.
- Priority: rst > start=0 > retrain > lock > timeout.
- retrain outside UP is ignored.
- start re-asserted while in OFF restarts a full sequence.
- Counter widths: $clog2(max+1) of their respective limits; no wrap, since all compares are against the limit.
- rst mid-sequence returns to the reset values on the next edge, regardless of state.

Decomposition:
- Package diff_link_pkg: state enum (OFF=0, ENABLE=1, SETTLE=2, TRAIN=3, UP=4, FAIL=5) and a cnt_width function.
- One sub-module, diff_lane_checker: per-lane toggle checker with prev flop, saturating counter and locked flag; inputs clr and frz. Instantiated N_LANES times in a generate loop.
- The top holds the FSM, stagger/settle/timeout counters, tog and the tx mux.

Test Plan:
- Bring-up, N_LANES=4, SETTLE=16, LOCK=8, rx_data looped back from tx_out:
  - rx_en bits rise at cycles 1, 17, 33, 49 after start.
  - TRAIN entered at cycle 81; link_up ~10 cycles later; lane_locked=4'hF.
- Lane 2 stuck at 0, other lanes looped back, TIMEOUT=1024:
  - lane_locked=4'b1011.
  - FAIL exactly 1024 cycles after TRAIN entry; train_fail=1.
  - start=0 then 1 -> clean restart.
- Lane 1 misses one toggle after 6 good toggles:
  - lane_locked[1] stays 0; its count restarts from 0.
  - Lock arrives 8 good toggles later.
- In UP, drive tx_data_in=4'hA -> tx_out=4'hA one cycle later.
- In UP, retrain pulse:
  - link_up=0 next cycle; tx_out shows pattern starting at 0.
  - Relock and link_up=1 again.
- Simultaneous and mid-sequence events:
  - start=0 during ENABLE with rx_en=4'b0011 -> rx_en=0, state=OFF next cycle.
  - rst during TRAIN -> all outputs at reset values next cycle.
  - start=0 together with retrain in UP -> OFF wins.

Source files
------------

// File: rtl/diff_link_pkg.sv
// Shared types and helpers for the differential lane bring-up controller.
package diff_link_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_ENABLE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TRAIN  = 3'd3,
    ST_UP     = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  // Bits needed for a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/diff_lane_checker.sv
// Per-lane toggle checker: counts consecutive toggles of rx_i and flags lock
// once LOCK_COUNT of them have been seen in a row.
module diff_lane_checker
  import diff_link_pkg::*;
#(
  parameter int LOCK_COUNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic frz_i,
  input  logic rx_i,
  output logic locked_o
);

  localparam int             CW       = cnt_width(LOCK_COUNT);
  localparam logic [CW-1:0]  LOCK_MAX = CW'(LOCK_COUNT);

  logic          have_prev_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          locked_q;

  // Next toggle count: saturating increment on a toggle, restart on a miss.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (rx_i != prev_q) begin
      if (cnt_q != LOCK_MAX) cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Lane state: first active cycle only captures prev, later cycles count.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst || clr_i) begin
      have_prev_q <= 1'b0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
    end else if (!frz_i) begin
      have_prev_q <= 1'b1;
      prev_q      <= rx_i;
      if (have_prev_q) begin
        cnt_q    <= cnt_d;
        locked_q <= (cnt_d == LOCK_MAX);
      end
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/diff_link_ctrl.sv
// Bring-up controller for a bank of differential lanes: staggered receiver
// enables, settle wait, toggle-pattern training, then user data pass-through.
module diff_link_ctrl
  import diff_link_pkg::*;
#(
  parameter int N_LANES        = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int LOCK_COUNT     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               retrain,
  input  logic [N_LANES-1:0] rx_data,
  input  logic [N_LANES-1:0] tx_data_in,
  output logic [N_LANES-1:0] rx_en,
  output logic [N_LANES-1:0] tx_out,
  output logic [N_LANES-1:0] lane_locked,
  output logic               link_up,
  output logic               train_fail,
  output logic [2:0]         state
);

  localparam int            SW           = cnt_width(SETTLE_CYCLES);
  localparam int            TW           = cnt_width(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  state_e             state_d;
  logic [SW-1:0]      stag_cnt_q;
  logic [TW-1:0]      tmo_cnt_q;
  logic               tog_q;
  logic [N_LANES-1:0] rx_en_q;
  logic [N_LANES-1:0] tx_out_q;
  logic               link_up_q;
  logic               train_fail_q;
  logic [N_LANES-1:0] locked;
  logic               chk_clr;
  logic               chk_frz;

  // Next state; start=0 beats retrain, which beats lock, which beats timeout.
  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:    state_d = ST_ENABLE;
        ST_ENABLE: if (stag_cnt_q == SETTLE_LAST && rx_en_q[N_LANES-1]) state_d = ST_SETTLE;
        ST_SETTLE: if (stag_cnt_q == SETTLE_LAST) state_d = ST_TRAIN;
        ST_TRAIN: begin
          if (&locked)                         state_d = ST_UP;
          else if (tmo_cnt_q == TIMEOUT_LAST)  state_d = ST_FAIL;
        end
        ST_UP:     if (retrain) state_d = ST_TRAIN;
        ST_FAIL:   state_d = ST_FAIL;
        default:   state_d = ST_OFF;
      endcase
    end
  end

  // Checkers restart on every TRAIN entry and only run while TRAIN persists,
  // so lane_locked holds its value in UP and FAIL.
  assign chk_clr = (state_d == ST_OFF) || (state_d == ST_TRAIN && state_q != ST_TRAIN);
  assign chk_frz = !(state_q == ST_TRAIN && state_d == ST_TRAIN);

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    diff_lane_checker #(
      .LOCK_COUNT(LOCK_COUNT)
    ) u_chk (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (chk_clr),
      .frz_i   (chk_frz),
      .rx_i    (rx_data[i]),
      .locked_o(locked[i])
    );
  end

  // FSM register, counters and registered outputs, all keyed on the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      stag_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      tog_q        <= 1'b0;
      rx_en_q      <= '0;
      tx_out_q     <= '0;
      link_up_q    <= 1'b0;
      train_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_up_q    <= (state_d == ST_UP);
      train_fail_q <= (state_d == ST_FAIL);
      case (state_d)
        ST_OFF: begin
          rx_en_q    <= '0;
          tx_out_q   <= '0;
          stag_cnt_q <= '0;
          tmo_cnt_q  <= '0;
          tog_q      <= 1'b0;
        end
        ST_ENABLE: begin
          tx_out_q <= '0;
          if (state_q != ST_ENABLE) begin
            rx_en_q    <= N_LANES'(1);
            stag_cnt_q <= '0;
          end else if (stag_cnt_q == SETTLE_LAST) begin
            rx_en_q    <= (rx_en_q << 1) | N_LANES'(1);
            stag_cnt_q <= '0;
          end else begin
            stag_cnt_q <= stag_cnt_q + SW'(1);
          end
        end
        ST_SETTLE: begin
          tx_out_q   <= '0;
          stag_cnt_q <= (state_q != ST_SETTLE) ? '0 : stag_cnt_q + SW'(1);
        end
        ST_TRAIN: begin
          if (state_q != ST_TRAIN) begin
            tog_q     <= 1'b0;
            tx_out_q  <= '0;
            tmo_cnt_q <= '0;
          end else begin
            tog_q     <= ~tog_q;
            tx_out_q  <= {N_LANES{~tog_q}};
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ST_UP:   tx_out_q <= tx_data_in;
        ST_FAIL: tx_out_q <= '0;
        default: tx_out_q <= '0;
      endcase
    end
  end

  assign rx_en       = rx_en_q;
  assign tx_out      = tx_out_q;
  assign lane_locked = locked;
  assign link_up     = link_up_q;
  assign train_fail  = train_fail_q;
  assign state       = state_q;

endmodule

// File: tb/tb_diff_link_ctrl.sv
// Self-checking bench for diff_link_ctrl: a phase/timer behavioural model is
// compared against the DUT every cycle, plus literal checks on key moments.
`timescale 1ns/1ps
module tb_diff_link_ctrl;

  localparam int N = 4;
  localparam int S = 16;
  localparam int L = 8;
  localparam int T = 1024;

  localparam int M_OFF = 0, M_EN = 1, M_SET = 2, M_TR = 3, M_UP = 4, M_FAIL = 5;

  logic         clk = 1'b0;
  logic         rst, start, retrain;
  logic [N-1:0] rx_data, tx_data_in, rx_en, tx_out, lane_locked;
  logic [N-1:0] inv_mask, stuck_mask;
  logic         link_up, train_fail;
  logic [2:0]   state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;

  always #5 clk = ~clk;

  // Loopback from the transmitters, with optional polarity flips and stuck lanes.
  assign rx_data = (tx_out ^ inv_mask) & ~stuck_mask;

  diff_link_ctrl #(
    .N_LANES(N), .SETTLE_CYCLES(S), .LOCK_COUNT(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .retrain(retrain),
    .rx_data(rx_data), .tx_data_in(tx_data_in),
    .rx_en(rx_en), .tx_out(tx_out), .lane_locked(lane_locked),
    .link_up(link_up), .train_fail(train_fail), .state(state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int           m_state, m_t;
  logic [N-1:0] m_rx_en, m_tx, m_locked, m_prev;
  bit           m_link, m_fail, m_have_prev;
  int           m_run [N];

  function automatic logic [N-1:0] low_ones(input int k);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  task automatic m_reset();
    m_state = M_OFF; m_t = 0; m_rx_en = '0; m_tx = '0; m_locked = '0;
    m_link = 0; m_fail = 0; m_have_prev = 0; m_prev = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic m_enter_train();
    m_state = M_TR; m_t = 0; m_tx = '0; m_locked = '0; m_have_prev = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  always @(posedge clk) begin
    cyc_n++;
    if (rst || !start) m_reset();
    else begin
      case (m_state)
        M_OFF: begin m_state = M_EN; m_t = 0; m_rx_en = low_ones(1); end
        M_EN: begin
          m_t++;
          if (m_t == N * S) begin m_state = M_SET; m_t = 0; end
          else m_rx_en = low_ones(m_t / S + 1);
        end
        M_SET: begin
          m_t++;
          if (m_t == S) m_enter_train();
        end
        M_TR: begin
          if (&m_locked) begin
            m_state = M_UP; m_link = 1; m_tx = tx_data_in;
          end else if (m_t == T - 1) begin
            m_state = M_FAIL; m_fail = 1; m_tx = '0;
          end else begin
            m_t++;
            if (m_have_prev) begin
              for (int i = 0; i < N; i++) begin
                if (rx_data[i] != m_prev[i]) m_run[i] = (m_run[i] < L) ? m_run[i] + 1 : L;
                else m_run[i] = 0;
                m_locked[i] = (m_run[i] == L);
              end
            end
            m_prev = rx_data; m_have_prev = 1;
            m_tx = (m_t % 2 == 1) ? '1 : '0;
          end
        end
        M_UP: begin
          if (retrain) begin m_link = 0; m_enter_train(); end
          else m_tx = tx_data_in;
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cyc_n >= 1)
      check($sformatf("cycle%0d", cyc_n),
            {state, rx_en, tx_out, lane_locked, link_up, train_fail},
            {3'(m_state), m_rx_en, m_tx, m_locked, m_link, m_fail});
  end

  task automatic go_to(input int k);
    while (cyc_n < k) @(negedge clk);
  endtask

  task automatic wait_link(input int budget, input string name);
    int k = 0;
    while (link_up !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    check(name, link_up, 1'b1);
  endtask

  int s, e;

  initial begin
    rst = 1'b1; start = 1'b0; retrain = 1'b0; tx_data_in = '0;
    inv_mask = '0; stuck_mask = '0;
    go_to(2);
    check("rst_state", state, 3'd0);
    check("rst_rx_en", rx_en, 4'h0);
    check("rst_tx_out", tx_out, 4'h0);
    check("rst_locked", lane_locked, 4'h0);
    check("rst_flags", {link_up, train_fail}, 2'b00);
    rst = 1'b0;
    go_to(4);

    // Full bring-up with clean loopback.
    s = cyc_n; start = 1'b1;
    go_to(s + 1);  check("en_bit0", rx_en, 4'b0001);
    go_to(s + 16); check("en_bit0_hold", rx_en, 4'b0001);
    go_to(s + 17); check("en_bit1", rx_en, 4'b0011);
    go_to(s + 33); check("en_bit2", rx_en, 4'b0111);
    go_to(s + 49); check("en_bit3", rx_en, 4'b1111);
    go_to(s + 80); check("settle_state", state, 3'd2);
    go_to(s + 81); check("train_entry", state, 3'd3);
    check("train_tx0", tx_out, 4'h0);
    go_to(s + 82); check("train_tx1", tx_out, 4'hF);
    go_to(s + 90); check("locked_all", lane_locked, 4'hF);
    check("not_up_yet", link_up, 1'b0);
    go_to(s + 91); check("link_up", link_up, 1'b1);
    check("model_up", m_state, M_UP);

    // Pass-through latency.
    tx_data_in = 4'hA; go_to(cyc_n + 1); check("pass_A", tx_out, 4'hA);
    tx_data_in = 4'h5; go_to(cyc_n + 1); check("pass_5", tx_out, 4'h5);

    // Retrain from UP.
    retrain = 1'b1; e = cyc_n + 1; go_to(e); retrain = 1'b0;
    check("retrain_link", link_up, 1'b0);
    check("retrain_tx", tx_out, 4'h0);
    check("retrain_locked", lane_locked, 4'h0);
    go_to(e + 1);  check("retrain_tx1", tx_out, 4'hF);
    go_to(e + 10); check("relock_up", link_up, 1'b1);

    // Lane 1 misses one toggle after six good ones (polarity slip).
    retrain = 1'b1; e = cyc_n + 1; go_to(e); retrain = 1'b0;
    go_to(e + 7);  inv_mask = 4'b0010;
    go_to(e + 9);  check("miss_partial", lane_locked, 4'b1101);
    go_to(e + 15); check("miss_lane1_low", lane_locked[1], 1'b0);
    go_to(e + 16); check("miss_relock", lane_locked, 4'hF);
    check("miss_not_up", link_up, 1'b0);
    go_to(e + 17); check("miss_up", link_up, 1'b1);
    inv_mask = '0;

    // start=0 together with retrain in UP: OFF wins.
    start = 1'b0; retrain = 1'b1; go_to(cyc_n + 1); retrain = 1'b0;
    check("off_wins_state", state, 3'd0);
    check("off_wins_link", link_up, 1'b0);
    check("off_wins_rx_en", rx_en, 4'h0);

    // Lane 2 stuck at 0 -> timeout.
    stuck_mask = 4'b0100; s = cyc_n; start = 1'b1; e = s + 81;
    go_to(e + 9);    check("stuck_locked", lane_locked, 4'b1011);
    go_to(e + 1023); check("stuck_still_train", state, 3'd3);
    go_to(e + 1024); check("stuck_fail", state, 3'd5);
    check("stuck_fail_flag", train_fail, 1'b1);
    check("stuck_fail_tx", tx_out, 4'h0);
    check("stuck_fail_rx_en", rx_en, 4'hF);
    go_to(e + 1030); check("fail_sticky", state, 3'd5);
    start = 1'b0; go_to(cyc_n + 1);
    check("fail_exit", {state, train_fail, lane_locked}, {3'd0, 1'b0, 4'h0});
    stuck_mask = '0; start = 1'b1;
    wait_link(120, "restart_up");

    // start=0 in the middle of ENABLE.
    start = 1'b0; go_to(cyc_n + 1);
    s = cyc_n; start = 1'b1;
    go_to(s + 17); check("abort_rx_en", rx_en, 4'b0011);
    start = 1'b0;
    go_to(s + 18); check("abort_off", {state, rx_en}, {3'd0, 4'h0});

    // rst during TRAIN.
    s = cyc_n; start = 1'b1;
    go_to(s + 84); check("pre_rst_train", state, 3'd3);
    rst = 1'b1;
    go_to(s + 85);
    check("rst_mid", {state, rx_en, tx_out, lane_locked, link_up, train_fail}, 17'h0);
    rst = 1'b0;

    // Randomised traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 999) == 0);
      start      = ($urandom_range(0, 399) != 0);
      retrain    = ($urandom_range(0, 63) == 0);
      tx_data_in = N'($urandom);
      if ($urandom_range(0, 149) == 0) inv_mask = N'($urandom);
      if ($urandom_range(0, 299) == 0) stuck_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
    end
    rst = 1'b0; start = 1'b0; retrain = 1'b0;
    go_to(cyc_n + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
